// File: rtl/lsu_mem_master.sv
// Load/store master for the MEM stage: word-interface requester with sub-word RMW stores.
// Define LSU_ALIGN_CHECK_EN to report misaligned half/word accesses as errors instead of aligning them down.
module lsu_mem_master #(
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW, WRITE, RESP} state_t;

  localparam logic [ADDR_W-2:0] LP_DEPTH = (ADDR_W-1)'(MEM_DEPTH);

  state_t            r_state, w_next;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_memWd;

  logic        w_outOfRange, w_misaligned, w_reqErr;
  logic [4:0]  w_shift;
  logic [15:0] w_rdHalf;
  logic [7:0]  w_rdByte;
  logic [31:0] w_loadData, w_mask, w_merged;

  assign w_outOfRange = {1'b0, req_addr[ADDR_W-1:2]} >= LP_DEPTH;
`ifdef LSU_ALIGN_CHECK_EN
  assign w_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif
  assign w_reqErr = (req_size == 2'd3) || w_outOfRange || w_misaligned;

  // Lane position of the latched access; halves ignore addr[0] so misalignment aligns down.
  assign w_shift  = (r_size == 2'd0) ? {r_addr[1:0], 3'b000} : {r_addr[1], 4'b0000};
  assign w_rdHalf = 16'(mem_rd >> w_shift);
  assign w_rdByte = w_rdHalf[7:0];
  assign w_mask   = ((r_size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
  assign w_merged = (mem_rd & ~w_mask) | ((r_wdata << w_shift) & w_mask);

  always_comb begin
    case (r_size)
      2'd0:    w_loadData = {{24{~r_unsigned & w_rdByte[7]}}, w_rdByte};
      2'd1:    w_loadData = {{16{~r_unsigned & w_rdHalf[15]}}, w_rdHalf};
      default: w_loadData = mem_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == RESP);
    mem_we     = (r_state == WRITE) && !rst;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_reqErr)               w_next = RESP;
          else if (!req_we)           w_next = LOAD;
          else if (req_size == 2'd2)  w_next = WRITE;
          else                        w_next = RMW;
        end
      end
      LOAD:    w_next = RESP;
      RMW:     w_next = WRITE;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch and datapath; responses stay stable until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
      r_memWd    <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= 32'h0;
            r_err      <= w_reqErr;
            if (req_we) r_memWd <= req_wdata;
          end
        end
        LOAD:    r_rdata <= w_loadData;
        RMW:     r_memWd <= w_merged;
        default: ;
      endcase
    end
  end

  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wd     = r_memWd;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: request-level reference model plus directed literal checks.
// Honours LSU_ALIGN_CHECK_EN the same way the design does.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

  lsu_mem_master #(.ADDR_W(32), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0, errors = 0;
  logic [31:0] tbMem [256];
  logic [31:0] refMem [256];
  int          expRespCycle = -1, expWeCycle = -1;
  logic        expErr;
  logic [31:0] expData, expWeAddr, expWeData;
  int          respCount = 0, weCount = 0, lastAcceptCycle = 0, lastRespCycle = 0;
  logic [31:0] lastRespData, lastWeAddr, lastWeData;
  logic        lastRespErr;

  function automatic logic [31:0] initWord(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5C3_0F1E;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory seen by the DUT: combinational read, clocked write.
  assign mem_rd = tbMem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (cyc == 0) for (int i = 0; i < 256; i++) tbMem[i] <= initWord(i);
    else if (mem_we) tbMem[mem_addr[9:2]] <= mem_wd;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  // Reference model: resolves each accepted request into its response and write, cycle-stamped.
  task automatic modelAccept();
    logic [31:0] word, newWord, b;
    logic        err;
    int          idx;
    err = (req_size == 2'd3) || (req_addr[31:2] >= 30'd256);
`ifdef LSU_ALIGN_CHECK_EN
    err = err || (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`endif
    idx = int'(req_addr[9:2]);
    lastAcceptCycle = cyc;
    expErr  = err;
    expData = 32'h0;
    if (err) begin
      expRespCycle = cyc + 1;
    end else if (!req_we) begin
      word = refMem[idx];
      if (req_size == 2'd0) begin
        b = (word >> (8 * req_addr[1:0])) & 32'hFF;
        expData = req_unsigned ? b : {{24{b[7]}}, b[7:0]};
      end else if (req_size == 2'd1) begin
        b = (word >> (16 * req_addr[1])) & 32'hFFFF;
        expData = req_unsigned ? b : {{16{b[15]}}, b[15:0]};
      end else begin
        expData = word;
      end
      expRespCycle = cyc + 2;
    end else begin
      newWord = refMem[idx];
      if (req_size == 2'd0)      newWord[8 * req_addr[1:0] +: 8] = req_wdata[7:0];
      else if (req_size == 2'd1) newWord[16 * req_addr[1] +: 16] = req_wdata[15:0];
      else                       newWord = req_wdata;
      expWeCycle   = cyc + ((req_size == 2'd2) ? 1 : 2);
      expRespCycle = expWeCycle + 1;
      expWeAddr    = {22'b0, req_addr[9:2], 2'b00};
      expWeData    = newWord;
    end
  endtask

  // Per-cycle compare of every output against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we) begin
      weCount++;
      lastWeAddr = mem_addr;
      lastWeData = mem_wd;
    end
    if (rst) begin
      checkOutput("memWeDuringReset", {31'b0, mem_we}, 32'h0);
      expRespCycle = -1;
      expWeCycle   = -1;
    end else begin
      checkOutput("reqReady", {31'b0, req_ready}, {31'b0, !(expRespCycle >= cyc)});
      checkOutput("respValid", {31'b0, resp_valid}, {31'b0, cyc == expRespCycle});
      if (resp_valid && cyc == expRespCycle) begin
        checkOutput("respErr", {31'b0, resp_err}, {31'b0, expErr});
        checkOutput("respRdata", resp_rdata, expData);
        respCount++;
        lastRespCycle = cyc;
        lastRespData  = resp_rdata;
        lastRespErr   = resp_err;
      end
      checkOutput("memWe", {31'b0, mem_we}, {31'b0, cyc == expWeCycle});
      if (mem_we && cyc == expWeCycle) begin
        checkOutput("memAddr", mem_addr, expWeAddr);
        checkOutput("memWd", mem_wd, expWeData);
        refMem[expWeAddr[9:2]] = expWeData;
      end
      if (req_valid && req_ready) modelAccept();
    end
  end

  // Presents a request from posedge+1 and returns just after the edge that accepts it.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      guard++;
      if (guard > 50) begin
        checks++; errors++;
        $display("[TB] FAIL acceptTimeout: got no ready, expected ready within 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic waitResp(input int n);
    int target;
    target = respCount + n;
    for (int i = 0; i < 40 && respCount < target; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("respArrived", respCount, target);
  endtask

  task automatic doOp(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    applyStimulus(we, size, uns, addr, wdata);
    req_valid = 1'b0;
    waitResp(1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_reqReady"}, {31'b0, req_ready}, 32'h1);
    checkOutput({tag, "_respValid"}, {31'b0, resp_valid}, 32'h0);
    checkOutput({tag, "_respRdata"}, resp_rdata, 32'h0);
    checkOutput({tag, "_respErr"}, {31'b0, resp_err}, 32'h0);
    checkOutput({tag, "_memWe"}, {31'b0, mem_we}, 32'h0);
    checkOutput({tag, "_memAddr"}, mem_addr, 32'h0);
    checkOutput({tag, "_memWd"}, mem_wd, 32'h0);
  endtask

  initial begin
    int weBefore, respBefore, mism, sel, sz;
    logic [31:0] wordIdx;
    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    weBefore = weCount;
    doOp(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    checkOutput("wordStoreWeCount", weCount - weBefore, 32'd1);
    checkOutput("wordStoreAddr", lastWeAddr, 32'h10);
    checkOutput("wordStoreData", lastWeData, 32'hDEAD_BEEF);
    doOp(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    checkOutput("wordLoadData", lastRespData, 32'hDEAD_BEEF);
    checkOutput("wordLoadErr", {31'b0, lastRespErr}, 32'h0);
    checkOutput("wordLoadLatency", lastRespCycle - lastAcceptCycle, 32'd2);

    doOp(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
    weBefore = weCount;
    doOp(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA);
    checkOutput("byteRmwWord", tbMem[8], 32'h11AA_3344);
    checkOutput("byteRmwWeCount", weCount - weBefore, 32'd1);
    checkOutput("byteRmwLatency", lastRespCycle - lastAcceptCycle, 32'd3);

    doOp(1'b1, 2'd2, 1'b0, 32'h30, 32'h0000_807F);
    doOp(1'b0, 2'd0, 1'b0, 32'h31, 32'h0);
    checkOutput("byteLoadSigned", lastRespData, 32'hFFFF_FF80);
    doOp(1'b0, 2'd0, 1'b1, 32'h31, 32'h0);
    checkOutput("byteLoadUnsigned", lastRespData, 32'h0000_0080);
    doOp(1'b0, 2'd1, 1'b0, 32'h30, 32'h0);
    checkOutput("halfLoadSigned", lastRespData, 32'hFFFF_807F);

    weBefore = weCount;
    doOp(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    checkOutput("rangeErr", {31'b0, lastRespErr}, 32'h1);
    checkOutput("rangeRdata", lastRespData, 32'h0);
    checkOutput("rangeWeCount", weCount - weBefore, 32'd0);
    checkOutput("rangeLatency", lastRespCycle - lastAcceptCycle, 32'd1);

    doOp(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    checkOutput("misalignErr", {31'b0, lastRespErr}, 32'h1);
    checkOutput("misalignRdata", lastRespData, 32'h0);
`else
    checkOutput("misalignErr", {31'b0, lastRespErr}, 32'h0);
    checkOutput("misalignRdata", lastRespData, 32'hDEAD_BEEF);
`endif

    // Reset lands in the WRITE cycle of a byte store: the write and its response must vanish.
    doOp(1'b1, 2'd2, 1'b0, 32'h40, 32'h5566_7788);
    respBefore = respCount;
    weBefore = weCount;
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h40, 32'h0000_00AB);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkResetOutputs("midReset");
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midResetMemWord", tbMem[16], 32'h5566_7788);
    checkOutput("midResetNoResp", respCount - respBefore, 32'd0);
    checkOutput("midResetNoWe", weCount - weBefore, 32'd0);

    respBefore = respCount;
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h30, 32'h0);
    req_valid = 1'b0;
    waitResp(1);
    checkOutput("backToBackCount", respCount - respBefore, 32'd3);
    checkOutput("backToBackLast", lastRespData, 32'h0000_007F);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      sel = $urandom_range(0, 15);
      wordIdx = (sel == 0) ? 32'($urandom_range(256, 600)) : 32'($urandom_range(0, 255));
      sz = $urandom_range(0, 9);
      applyStimulus(1'($urandom_range(0, 1)), (sz == 9) ? 2'd3 : 2'(sz / 3), 1'($urandom_range(0, 1)),
                    (wordIdx << 2) | 32'($urandom_range(0, 3)), $urandom);
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    mism = 0;
    for (int i = 0; i < 256; i++) if (tbMem[i] !== refMem[i]) mism++;
    checkOutput("memoryImage", mism, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
